// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and helper functions for the MEM stage.
// Counter width here bounds the MEM_TIMEOUT_EN abort counter.
package mem_pkg;

    typedef enum logic [2:0] {
        RB_LB  = 3'b001,
        RB_LH  = 3'b010,
        RB_LW  = 3'b011,
        RB_LBU = 3'b101,
        RB_LHU = 3'b110
    } mem_rbits_e;

    typedef enum logic [1:0] {
        WR_BYTE = 2'b01,
        WR_HALF = 2'b10,
        WR_WORD = 2'b11
    } mem_wrbits_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int TIMEOUT_CNT_W = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  memtoreg;
    } memwb_t;

    // Load and store size encodings share their low two bits, so one size code serves both.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            WR_BYTE: be = 4'b0001 << addr_lo;
            WR_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            WR_BYTE: lanes = {4{data[7:0]}};
            WR_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == WR_HALF) && addr_lo[0]) || ((size == WR_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane select and sign/zero extension for the MEM stage.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rbits,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (rbits)
            RB_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            RB_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            RB_LBU:  load_data = {24'd0, byte_lane};
            RB_LHU:  load_data = {16'd0, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage plus MEM/WB register with req/ack data-memory bus.
// Optional bus-error timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EXMEMInstruction,
    input  logic [31:0] EXMEMPCPlus4,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMMemWriteData,
    input  logic [4:0]  EXMEMRegRd,
    input  logic        EXMEMRegWrite,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [1:0]  EXMEMMemtoReg,
    input  logic [1:0]  EXMEMMemWrBits,
    input  logic [2:0]  EXMEMMemRBits,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        MemStall,
    output logic        MisalignExc,
    output logic        BusErr,
    output logic [31:0] MEMWBInstruction,
    output logic [31:0] MEMWBPCPlus4,
    output logic [31:0] MEMWBALUResult,
    output logic [31:0] MEMWBReadData,
    output logic [4:0]  MEMWBRegRd,
    output logic        MEMWBRegWrite,
    output logic [1:0]  MEMWBMemtoReg
);

    mem_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    memwb_t      wb_q, wb_d;
    memwb_t      payload;

    logic        access;
    logic [1:0]  size;
    logic        misaligned;
    logic [31:0] load_aligned;
    logic        timed_out;

    assign access     = EXMEMMemRead | EXMEMMemWrite;
    assign size       = EXMEMMemRead ? EXMEMMemRBits[1:0] : EXMEMMemWrBits;
    assign misaligned = access & is_misaligned(size, EXMEMALUResult[1:0]);

    mem_load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr_lo   (EXMEMALUResult[1:0]),
        .rbits     (EXMEMMemRBits),
        .load_data (load_aligned)
    );

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
    logic                     timed_out_q, timed_out_d;
    logic                     bus_err_q, bus_err_d;
    logic                     cnt_expired;

    assign cnt_expired = (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));
    assign timed_out   = timed_out_q;
    assign BusErr      = bus_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timed_out      = 1'b0;
    assign BusErr         = 1'b0;
`endif

    // While an access is in flight MEM/WB carries a bubble so write-back never sees it twice.
    always_comb begin
        payload          = '0;
        payload.instr    = EXMEMInstruction;
        payload.pc4      = EXMEMPCPlus4;
        payload.alu      = EXMEMALUResult;
        payload.rd       = EXMEMRegRd;
        payload.regwrite = EXMEMRegWrite;
        payload.memtoreg = EXMEMMemtoReg;

        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        wb_d       = wb_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        bus_err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = EXMEMMemWrite;
                    addr_d  = {EXMEMALUResult[31:2], 2'b00};
                    be_d    = byte_enable(size, EXMEMALUResult[1:0]);
                    wdata_d = EXMEMMemWrite ? store_lanes(size, EXMEMMemWriteData) : 32'd0;
                    wb_d    = '0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
`endif
                end else if (access) begin
                    wb_d       = '0;
                    misalign_d = 1'b1;
                end else begin
                    wb_d = payload;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_aligned;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_expired) begin
                    state_d     = DONE;
                    req_d       = 1'b0;
                    rdata_d     = 32'd0;
                    timed_out_d = 1'b1;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d       = IDLE;
                wb_d          = payload;
                wb_d.rdata    = rdata_q;
                wb_d.regwrite = EXMEMRegWrite & ~timed_out;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            wb_q       <= wb_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            bus_err_q   <= bus_err_d;
        end
    end
`endif

    // DONE releases the stall so EX/MEM advances on the same edge that loads MEM/WB.
    assign MemStall = ((state_q == IDLE) && access && !misaligned) || (state_q == BUSY);

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign MisalignExc      = misalign_q;
    assign MEMWBInstruction = wb_q.instr;
    assign MEMWBPCPlus4     = wb_q.pc4;
    assign MEMWBALUResult   = wb_q.alu;
    assign MEMWBReadData    = wb_q.rdata;
    assign MEMWBRegRd       = wb_q.rd;
    assign MEMWBRegWrite    = wb_q.regwrite;
    assign MEMWBMemtoReg    = wb_q.memtoreg;

endmodule
